// File: rtl/shared_mem_port_arbiter_if.sv
// Port B bundle of the shared block RAM: two requester channels, their grant and
// read-return signals, and the RAM pin side driven by the arbiter.
interface shared_mem_port_arbiter_if #(
    parameter int AW = 11,
    parameter int DW = 32
);
    logic              prog_mode;
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [DW/8-1:0]   be0;
    logic [DW/8-1:0]   be1;
    logic [AW-1:0]     addr0;
    logic [AW-1:0]     addr1;
    logic [DW-1:0]     wdata0;
    logic [DW-1:0]     wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DW-1:0]     rdata0;
    logic [DW-1:0]     rdata1;
    logic              mem_en;
    logic [DW/8-1:0]   mem_web;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_din;
    logic [DW-1:0]     mem_dout;

    modport slave (
        input  prog_mode, req0, req1, we0, we1, be0, be1,
        input  addr0, addr1, wdata0, wdata1, mem_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_en, mem_web, mem_addr, mem_din
    );

    modport master (
        output prog_mode, req0, req1, we0, we1, be0, be1,
        output addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
    );

    modport mem (
        input  mem_en, mem_web, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/shared_mem_port_arbiter.sv
// Two-requester arbiter for block RAM port B: round-robin under contention, loader
// priority in prog_mode, and a one-entry tag steering each read return.
module shared_mem_port_arbiter #(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic                     clk,
    input  logic                     Rst,
    shared_mem_port_arbiter_if.slave bus
);
    localparam int BW = DW / 8;

    logic          rr;
    logic          rtag_valid;
    logic          rtag_idx;
    logic          grant;
    logic          win1;
    logic          win_we;
    logic [BW-1:0] win_be;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    // Reset gates the grant itself so neither the RAM nor the tag see a stray access.
    assign grant = (bus.req0 | bus.req1) & ~Rst;
    assign win1  = bus.req1 & (~bus.req0 | bus.prog_mode | rr);

    assign win_we    = win1 ? bus.we1    : bus.we0;
    assign win_be    = win1 ? bus.be1    : bus.be0;
    assign win_addr  = win1 ? bus.addr1  : bus.addr0;
    assign win_wdata = win1 ? bus.wdata1 : bus.wdata0;

    assign bus.gnt0     = grant & ~win1;
    assign bus.gnt1     = grant & win1;
    assign bus.mem_en   = grant;
    assign bus.mem_addr = grant ? win_addr  : '0;
    assign bus.mem_din  = grant ? win_wdata : '0;
    assign bus.mem_web  = (grant & win_we) ? win_be : '0;

    assign bus.rvalid0 = rtag_valid & ~rtag_idx;
    assign bus.rvalid1 = rtag_valid & rtag_idx;
    assign bus.rdata0  = bus.mem_dout;
    assign bus.rdata1  = bus.mem_dout;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            rr         <= 1'b0;
            rtag_valid <= 1'b0;
            rtag_idx   <= 1'b0;
        end else begin
            rtag_valid <= grant & ~win_we;
            if (grant) begin
                rr       <= ~win1;
                rtag_idx <= win1;
            end
        end
    end
endmodule

// File: tb/tb_shared_mem_port_arbiter.sv
// Directed bench for shared_mem_port_arbiter: per-cycle vector table plus
// hand sequences for reset during pending reads.
module tb_shared_mem_port_arbiter;
    localparam logic [31:0] M0 = 32'h0A0A_0000;
    localparam logic [31:0] M1 = 32'h0B0B_0001;
    localparam logic [31:0] M2 = 32'h0C0C_0002;
    localparam logic [31:0] M3 = 32'h0D0D_0003;
    localparam int NV = 27;

    typedef struct {
        logic        pm;
        logic        r0;
        logic        w0;
        logic [3:0]  b0;
        logic [10:0] a0;
        logic [31:0] d0;
        logic        r1;
        logic        w1;
        logic [3:0]  b1;
        logic [10:0] a1;
        logic [31:0] d1;
        logic        eg0;
        logic        eg1;
        logic        ev0;
        logic        ev1;
        logic [31:0] erd;
    } vec_t;

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic        load_en = 1'b0;
    logic [10:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic [31:0] ram [0:2047];
    int          errors = 0;
    int          checks = 0;
    vec_t        vecs [NV];

    shared_mem_port_arbiter_if #(.AW(11), .DW(32)) bus ();

    shared_mem_port_arbiter #(.AW(11), .DW(32)) dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_en) begin
            ram[load_addr] <= load_data;
        end else if (bus.mem_en) begin
            for (int i = 0; i < 4; i++)
                if (bus.mem_web[i]) ram[bus.mem_addr][i*8 +: 8] <= bus.mem_din[i*8 +: 8];
            if (bus.mem_web == 4'b0) bus.mem_dout <= ram[bus.mem_addr];
        end
    end

    function automatic vec_t mk(input logic pm,
                                input logic r0, input logic w0, input logic [3:0] b0,
                                input logic [10:0] a0, input logic [31:0] d0,
                                input logic r1, input logic w1, input logic [3:0] b1,
                                input logic [10:0] a1, input logic [31:0] d1,
                                input logic eg0, input logic eg1,
                                input logic ev0, input logic ev1, input logic [31:0] erd);
        vec_t v;
        v.pm = pm; v.r0 = r0; v.w0 = w0; v.b0 = b0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.b1 = b1; v.a1 = a1; v.d1 = d1;
        v.eg0 = eg0; v.eg1 = eg1; v.ev0 = ev0; v.ev1 = ev1; v.erd = erd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [10:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.prog_mode = 0; bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.be0 = '0; bus.be1 = '0; bus.addr0 = '0; bus.addr1 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0;
    endtask

    task automatic run_row(input int n, input vec_t v);
        logic [10:0] ea;
        logic [3:0]  ew;
        logic [31:0] ed;
        @(posedge clk); #1;
        bus.prog_mode = v.pm;
        bus.req0 = v.r0; bus.we0 = v.w0; bus.be0 = v.b0; bus.addr0 = v.a0; bus.wdata0 = v.d0;
        bus.req1 = v.r1; bus.we1 = v.w1; bus.be1 = v.b1; bus.addr1 = v.a1; bus.wdata1 = v.d1;
        ea = v.eg1 ? v.a1 : (v.eg0 ? v.a0 : 11'd0);
        ed = v.eg1 ? v.d1 : (v.eg0 ? v.d0 : 32'd0);
        ew = v.eg1 ? (v.w1 ? v.b1 : 4'd0) : (v.eg0 ? (v.w0 ? v.b0 : 4'd0) : 4'd0);
        @(negedge clk);
        chk($sformatf("row%0d gnt0", n), 32'(bus.gnt0), 32'(v.eg0));
        chk($sformatf("row%0d gnt1", n), 32'(bus.gnt1), 32'(v.eg1));
        chk($sformatf("row%0d mem_en", n), 32'(bus.mem_en), 32'(v.eg0 | v.eg1));
        chk($sformatf("row%0d mem_addr", n), 32'(bus.mem_addr), 32'(ea));
        chk($sformatf("row%0d mem_web", n), 32'(bus.mem_web), 32'(ew));
        chk($sformatf("row%0d mem_din", n), bus.mem_din, ed);
        chk($sformatf("row%0d rvalid0", n), 32'(bus.rvalid0), 32'(v.ev0));
        chk($sformatf("row%0d rvalid1", n), 32'(bus.rvalid1), 32'(v.ev1));
        if (v.ev0) chk($sformatf("row%0d rdata0", n), bus.rdata0, v.erd);
        if (v.ev1) chk($sformatf("row%0d rdata1", n), bus.rdata1, v.erd);
    endtask

    initial begin
        // pm | req0 we0 be0 addr0 wdata0 | req1 we1 be1 addr1 wdata1 | gnt0 gnt1 rv0 rv1 rdata
        vecs[0]  = mk(0, 1,0,4'h0,11'h005,0,           0,0,4'h0,11'h000,0,            1,0,0,0,0);
        vecs[1]  = mk(0, 0,0,4'h0,11'h000,0,           0,0,4'h0,11'h000,0,            0,0,1,0,32'hDEADBEEF);
        vecs[2]  = mk(0, 0,0,4'h0,11'h000,0,           1,1,4'b0100,11'h010,32'h00AB0000, 0,1,0,0,0);
        vecs[3]  = mk(0, 0,0,4'h0,11'h000,0,           1,0,4'h0,11'h010,0,            0,1,0,0,0);
        vecs[4]  = mk(0, 0,0,4'h0,11'h000,0,           0,0,4'h0,11'h000,0,            0,0,0,1,32'h11AB3344);
        vecs[5]  = mk(0, 1,0,4'h0,11'h000,0,           1,0,4'h0,11'h001,0,            1,0,0,0,0);
        vecs[6]  = mk(0, 1,0,4'h0,11'h000,0,           1,0,4'h0,11'h001,0,            0,1,1,0,M0);
        vecs[7]  = mk(0, 1,0,4'h0,11'h000,0,           1,0,4'h0,11'h001,0,            1,0,0,1,M1);
        vecs[8]  = mk(0, 1,0,4'h0,11'h000,0,           1,0,4'h0,11'h001,0,            0,1,1,0,M0);
        vecs[9]  = mk(0, 1,0,4'h0,11'h000,0,           1,0,4'h0,11'h001,0,            1,0,0,1,M1);
        vecs[10] = mk(0, 1,0,4'h0,11'h000,0,           1,0,4'h0,11'h001,0,            0,1,1,0,M0);
        vecs[11] = mk(0, 0,0,4'h0,11'h000,0,           0,0,4'h0,11'h000,0,            0,0,0,1,M1);
        vecs[12] = mk(1, 1,0,4'h0,11'h002,0,           1,0,4'h0,11'h003,0,            0,1,0,0,0);
        vecs[13] = mk(1, 1,0,4'h0,11'h002,0,           1,0,4'h0,11'h003,0,            0,1,0,1,M3);
        vecs[14] = mk(1, 1,0,4'h0,11'h002,0,           1,0,4'h0,11'h003,0,            0,1,0,1,M3);
        vecs[15] = mk(1, 1,0,4'h0,11'h002,0,           1,0,4'h0,11'h003,0,            0,1,0,1,M3);
        vecs[16] = mk(0, 1,0,4'h0,11'h002,0,           1,0,4'h0,11'h003,0,            1,0,0,1,M3);
        vecs[17] = mk(0, 0,0,4'h0,11'h000,0,           0,0,4'h0,11'h000,0,            0,0,1,0,M2);
        vecs[18] = mk(0, 1,0,4'h0,11'h000,0,           0,0,4'h0,11'h000,0,            1,0,0,0,0);
        vecs[19] = mk(0, 1,0,4'h0,11'h001,0,           0,0,4'h0,11'h000,0,            1,0,1,0,M0);
        vecs[20] = mk(0, 1,0,4'h0,11'h002,0,           0,0,4'h0,11'h000,0,            1,0,1,0,M1);
        vecs[21] = mk(0, 1,0,4'h0,11'h003,0,           0,0,4'h0,11'h000,0,            1,0,1,0,M2);
        vecs[22] = mk(0, 0,0,4'h0,11'h000,0,           0,0,4'h0,11'h000,0,            0,0,1,0,M3);
        vecs[23] = mk(0, 1,1,4'hF,11'h020,32'h55,      1,0,4'h0,11'h005,0,            0,1,0,0,0);
        vecs[24] = mk(0, 1,1,4'hF,11'h020,32'h55,      0,0,4'h0,11'h000,0,            1,0,0,1,32'hDEADBEEF);
        vecs[25] = mk(0, 1,0,4'h0,11'h020,0,           0,0,4'h0,11'h000,0,            1,0,0,0,0);
        vecs[26] = mk(0, 0,0,4'h0,11'h000,0,           0,0,4'h0,11'h000,0,            0,0,1,0,32'h00000055);

        idle_inputs();
        bus.req0 = 1; bus.req1 = 1;
        #1;
        load(11'h000, M0);
        load(11'h001, M1);
        load(11'h002, M2);
        load(11'h003, M3);
        load(11'h005, 32'hDEADBEEF);
        load(11'h010, 32'h11223344);

        @(negedge clk);
        chk("rst gnt0", 32'(bus.gnt0), 0);
        chk("rst gnt1", 32'(bus.gnt1), 0);
        chk("rst mem_en", 32'(bus.mem_en), 0);
        chk("rst rvalid0", 32'(bus.rvalid0), 0);
        chk("rst rvalid1", 32'(bus.rvalid1), 0);
        @(posedge clk); #1;
        idle_inputs();
        Rst = 0;

        for (int i = 0; i < NV; i++) run_row(i, vecs[i]);

        // Reset arriving while a read tag is already pending clears rvalid at once.
        @(posedge clk); #1;
        idle_inputs();
        bus.req0 = 1; bus.addr0 = 11'h005;
        @(negedge clk);
        chk("seqA gnt0", 32'(bus.gnt0), 1);
        @(posedge clk); #1;
        bus.req0 = 0;
        chk("seqA rvalid0 before rst", 32'(bus.rvalid0), 1);
        Rst = 1; #1;
        chk("seqA rvalid0 async clear", 32'(bus.rvalid0), 0);
        @(posedge clk); #1;
        Rst = 0;

        // Reset landing inside a read grant: no return, and rr back to 0.
        @(posedge clk); #1;
        bus.req0 = 1; bus.addr0 = 11'h000;
        @(negedge clk);
        chk("seqB gnt0", 32'(bus.gnt0), 1);
        @(posedge clk); #1;
        bus.req0 = 0; bus.req1 = 1; bus.addr1 = 11'h005;
        @(negedge clk);
        chk("seqB gnt1", 32'(bus.gnt1), 1);
        #2 Rst = 1; #1;
        chk("seqB gnt1 forced", 32'(bus.gnt1), 0);
        chk("seqB mem_en forced", 32'(bus.mem_en), 0);
        @(posedge clk); #1;
        bus.req1 = 0;
        @(negedge clk);
        chk("seqB rvalid1 in rst", 32'(bus.rvalid1), 0);
        @(posedge clk); #1;
        Rst = 0;
        @(negedge clk);
        chk("seqB rvalid1 after rst", 32'(bus.rvalid1), 0);
        @(posedge clk); #1;
        bus.req0 = 1; bus.req1 = 1; bus.addr0 = 11'h001;
        @(negedge clk);
        chk("seqB first contended gnt0", 32'(bus.gnt0), 1);
        chk("seqB first contended gnt1", 32'(bus.gnt1), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("seqB second contended gnt1", 32'(bus.gnt1), 1);
        chk("seqB rvalid0 data", bus.rvalid0 ? bus.rdata0 : 32'hFFFF_FFFF, M1);
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
